// File: rtl/pistorm_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pistorm_pkg
// Brief   : Shared types for the 68000 bus arbiter. Holds the arbitration
//           state encoding and the status-register bit positions that
//           software uses to read bus ownership.
// Rev     : 1.0  initial release
// ============================================================================
package pistorm_pkg;

    // Bus mastership states, shared with status readback logic
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOCAL   = 3'd1,
        ARB     = 3'd2,
        GRANT   = 3'd3,
        EXT     = 3'd4,
        RECOVER = 3'd5
    } arb_state_t;

    // Status register layout: ownership flag plus the raw state field
    localparam int c_stat_ext_owner_bit = 0;
    localparam int c_stat_arb_state_lsb = 1;
    localparam int c_stat_arb_state_msb = 3;

endpackage : pistorm_pkg
`default_nettype wire

// File: rtl/m68k_bus_arbiter_sync_bit.sv
`default_nettype none
// ============================================================================
// Module  : sync_bit
// Brief   : SYNC_STAGES-deep flop chain bringing one asynchronous bus pin
//           into the c200m domain. Reset value is selectable so idle-high
//           active-low pins come out of reset in their inactive level.
// Rev     : 1.0  initial release
// ============================================================================
module sync_bit #(
    parameter int   SYNC_STAGES = 2,     // must be >= 2
    parameter logic RESET_VAL   = 1'b1
) (
    input  logic c200m,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] r_chain;

    // Shift the raw pin through the chain; reset presets every stage
    always_ff @(posedge c200m or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = r_chain[SYNC_STAGES-1];

endmodule : sync_bit
`default_nettype wire

// File: rtl/m68k_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : m68k_bus_arbiter
// Brief   : Owns 68000 bus mastership between the local cycle engine and an
//           external DMA master (BR_n/BG_n/BGACK_n). Gates local cycle
//           starts, drives BG_n and controls our bus-control tri-states.
// Rev     : 1.0  initial release
// ============================================================================
module m68k_bus_arbiter
    import pistorm_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,   // >= 2
    parameter int GRANT_TIMEOUT  = 16,  // >= 1
    parameter int RECOVER_CYCLES = 1    // >= 1
) (
    input  logic c200m,
    input  logic rst_n,
    input  logic c7m_rising,
    input  logic c7m_falling,
    input  logic br_n,
    input  logic bgack_n,
    input  logic as_n,
    input  logic bus_reset,
    input  logic local_req,
    input  logic local_done,
    output logic local_grant,
    output logic bg_n,
    output logic drive_en,
    output logic ext_owner
);

    localparam int c_to_w = $clog2(GRANT_TIMEOUT + 1);
    localparam int c_rc_w = $clog2(RECOVER_CYCLES + 1);

    localparam logic [c_to_w-1:0] c_to_max = c_to_w'(GRANT_TIMEOUT);
    localparam logic [c_to_w-1:0] c_to_one = c_to_w'(1);
    localparam logic [c_rc_w-1:0] c_rc_max = c_rc_w'(RECOVER_CYCLES);
    localparam logic [c_rc_w-1:0] c_rc_one = c_rc_w'(1);

    // Synchronised pin copies; decisions never look at the raw pins
    logic w_br_s;
    logic w_bgack_s;
    logic w_as_s;

    // Only the rising bus-clock edge paces arbitration
    logic w_unused_falling;
    assign w_unused_falling = c7m_falling;

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [c_to_w-1:0] r_to_cnt;
    logic [c_to_w-1:0] w_to_cnt_nxt;
    logic [c_to_w-1:0] w_to_inc;
    logic [c_rc_w-1:0] r_rc_cnt;
    logic [c_rc_w-1:0] w_rc_cnt_nxt;
    logic [c_rc_w-1:0] w_rc_inc;

    logic r_local_grant;
    logic r_bg_n;
    logic r_drive_en;
    logic r_ext_owner;
    logic w_local_grant_nxt;
    logic w_bg_n_nxt;
    logic w_drive_en_nxt;
    logic w_ext_owner_nxt;

    sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_br (
        .c200m (c200m),
        .rst_n (rst_n),
        .d     (br_n),
        .q     (w_br_s)
    );

    sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_bgack (
        .c200m (c200m),
        .rst_n (rst_n),
        .d     (bgack_n),
        .q     (w_bgack_s)
    );

    sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_as (
        .c200m (c200m),
        .rst_n (rst_n),
        .d     (as_n),
        .q     (w_as_s)
    );

    // Saturating increments so neither counter can ever wrap
    assign w_to_inc = (r_to_cnt == c_to_max) ? r_to_cnt : (r_to_cnt + c_to_one);
    assign w_rc_inc = (r_rc_cnt == c_rc_max) ? r_rc_cnt : (r_rc_cnt + c_rc_one);

    // Next-state, counter and registered-output decode
    always_comb begin
        w_state_nxt  = r_state;
        w_to_cnt_nxt = '0;
        w_rc_cnt_nxt = '0;

        if (bus_reset) begin
            // Bus-wide reset drops everything, including an in-flight local cycle
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    // External request beats a simultaneous local request
                    if (!w_br_s) begin
                        w_state_nxt = ARB;
                    end else if (local_req && w_bgack_s) begin
                        w_state_nxt = LOCAL;
                    end
                end
                LOCAL: begin
                    // A started cycle always runs to S7; BR waits behind it
                    if (local_done) begin
                        w_state_nxt = IDLE;
                    end
                end
                ARB: begin
                    // Grant only once the current bus cycle has ended
                    if (w_as_s && c7m_rising) begin
                        w_state_nxt = GRANT;
                    end
                end
                GRANT: begin
                    w_to_cnt_nxt = r_to_cnt;
                    if (!w_bgack_s) begin
                        w_state_nxt  = EXT;
                        w_to_cnt_nxt = '0;
                    end else if (!w_br_s) begin
                        w_to_cnt_nxt = '0;
                    end else if (c7m_rising) begin
                        if (w_to_inc == c_to_max) begin
                            w_state_nxt  = IDLE;
                            w_to_cnt_nxt = '0;
                        end else begin
                            w_to_cnt_nxt = w_to_inc;
                        end
                    end
                end
                EXT: begin
                    // BR is not looked at until recovery completes
                    if (w_bgack_s) begin
                        w_state_nxt = RECOVER;
                    end
                end
                RECOVER: begin
                    w_rc_cnt_nxt = r_rc_cnt;
                    if (c7m_rising) begin
                        if (w_rc_inc == c_rc_max) begin
                            w_state_nxt  = IDLE;
                            w_rc_cnt_nxt = '0;
                        end else begin
                            w_rc_cnt_nxt = w_rc_inc;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end

        w_local_grant_nxt = (w_state_nxt == LOCAL);
        w_bg_n_nxt        = (w_state_nxt != GRANT);
        w_drive_en_nxt    = (w_state_nxt == IDLE) || (w_state_nxt == LOCAL) ||
                            (w_state_nxt == ARB);
        w_ext_owner_nxt   = (w_state_nxt == EXT) || (w_state_nxt == RECOVER);
    end

    // State, counters and glitch-free registered pad controls
    always_ff @(posedge c200m or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_to_cnt      <= '0;
            r_rc_cnt      <= '0;
            r_local_grant <= 1'b0;
            r_bg_n        <= 1'b1;
            r_drive_en    <= 1'b1;
            r_ext_owner   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_to_cnt      <= w_to_cnt_nxt;
            r_rc_cnt      <= w_rc_cnt_nxt;
            r_local_grant <= w_local_grant_nxt;
            r_bg_n        <= w_bg_n_nxt;
            r_drive_en    <= w_drive_en_nxt;
            r_ext_owner   <= w_ext_owner_nxt;
        end
    end

    assign local_grant = r_local_grant;
    assign bg_n        = r_bg_n;
    assign drive_en    = r_drive_en;
    assign ext_owner   = r_ext_owner;

endmodule : m68k_bus_arbiter
`default_nettype wire

// File: tb/tb_m68k_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_m68k_bus_arbiter
// Brief   : Self-checking bench for m68k_bus_arbiter. Expected output words
//           {local_grant, bg_n, drive_en, ext_owner} are queued as stimulus
//           is applied and popped against the DUT after the edges elapse.
// Rev     : 1.0  initial release
// ============================================================================
module tb_m68k_bus_arbiter;

    logic c200m;
    logic rst_n;
    logic c7m_rising;
    logic c7m_falling;
    logic br_n;
    logic bgack_n;
    logic as_n;
    logic bus_reset;
    logic local_req;
    logic local_done;
    logic local_grant;
    logic bg_n;
    logic drive_en;
    logic ext_owner;

    logic [3:0] outs;
    assign outs = {local_grant, bg_n, drive_en, ext_owner};

    int total = 0;
    int bad   = 0;

    string      tag_q[$];
    logic [3:0] val_q[$];

    m68k_bus_arbiter #(
        .SYNC_STAGES    (2),
        .GRANT_TIMEOUT  (16),
        .RECOVER_CYCLES (1)
    ) dut (
        .c200m       (c200m),
        .rst_n       (rst_n),
        .c7m_rising  (c7m_rising),
        .c7m_falling (c7m_falling),
        .br_n        (br_n),
        .bgack_n     (bgack_n),
        .as_n        (as_n),
        .bus_reset   (bus_reset),
        .local_req   (local_req),
        .local_done  (local_done),
        .local_grant (local_grant),
        .bg_n        (bg_n),
        .drive_en    (drive_en),
        .ext_owner   (ext_owner)
    );

    initial c200m = 1'b0;
    always #5 c200m = ~c200m;

    task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got {lg,bg_n,de,ext}=%b expected %b", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [3:0] v);
        tag_q.push_back(tag);
        val_q.push_back(v);
    endtask

    task automatic sb_check();
        string      t;
        logic [3:0] v;
        if (val_q.size() == 0) begin
            check_val("sb_underflow", 4'd1, 4'd0);
        end else begin
            t = tag_q.pop_front();
            v = val_q.pop_front();
            check_val(t, outs, v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge c200m);
    endtask

    // One bus-clock rising strobe seen by exactly one c200m edge
    task automatic pulse_c7m();
        c7m_rising = 1'b1;
        @(negedge c200m);
        c7m_rising = 1'b0;
    endtask

    task automatic pulse_done();
        local_done = 1'b1;
        @(negedge c200m);
        local_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        c7m_rising  = 1'b0;
        c7m_falling = 1'b0;
        br_n        = 1'b1;
        bgack_n     = 1'b1;
        as_n        = 1'b1;
        bus_reset   = 1'b0;
        local_req   = 1'b0;
        local_done  = 1'b0;

        #12;
        sb_push("reset", 4'b0110);
        sb_check();
        @(negedge c200m);
        rst_n = 1'b1;
        tick(1);

        // Local cycle: grant one edge after request, drop on done
        local_req = 1'b1;
        sb_push("lgrant", 4'b1110);
        tick(1);
        sb_check();
        local_req = 1'b0;
        sb_push("ldone", 4'b0110);
        pulse_done();
        sb_check();
        sb_push("done_idle_ignored", 4'b0110);
        pulse_done();
        sb_check();

        // BR while AS busy: no grant until AS negates
        as_n = 1'b0;
        br_n = 1'b0;
        tick(3);
        sb_push("arb_as_busy", 4'b0110);
        pulse_c7m();
        sb_check();
        as_n = 1'b1;
        tick(3);
        sb_push("bg_low", 4'b0000);
        pulse_c7m();
        sb_check();

        // BGACK handshake, local request held throughout
        bgack_n   = 1'b0;
        local_req = 1'b1;
        sb_push("bg_hold_sync", 4'b0000);
        tick(2);
        sb_check();
        sb_push("ext", 4'b0101);
        tick(1);
        sb_check();
        br_n = 1'b1;
        sb_push("ext_hold", 4'b0101);
        tick(3);
        sb_check();
        bgack_n = 1'b1;
        sb_push("recover", 4'b0101);
        tick(3);
        sb_check();
        sb_push("recovered", 4'b0110);
        pulse_c7m();
        sb_check();
        sb_push("lgrant_after_ext", 4'b1110);
        tick(1);
        sb_check();
        local_req = 1'b0;
        sb_push("ldone2", 4'b0110);
        pulse_done();
        sb_check();

        // Grant timeout with a BR re-assertion clearing the count midway
        br_n = 1'b0;
        tick(3);
        sb_push("to_grant", 4'b0000);
        pulse_c7m();
        sb_check();
        br_n = 1'b1;
        tick(3);
        repeat (5) pulse_c7m();
        br_n = 1'b0;
        tick(3);
        repeat (2) pulse_c7m();
        sb_push("to_rearm", 4'b0000);
        sb_check();
        br_n = 1'b1;
        tick(3);
        repeat (15) pulse_c7m();
        sb_push("to_pre", 4'b0000);
        sb_check();
        sb_push("to_expire", 4'b0110);
        pulse_c7m();
        sb_check();

        // BR and local request reach the FSM on the same edge: BR wins
        br_n = 1'b0;
        tick(2);
        local_req = 1'b1;
        sb_push("sim_arb", 4'b0110);
        tick(1);
        sb_check();
        sb_push("sim_grant", 4'b0000);
        pulse_c7m();
        sb_check();
        bgack_n = 1'b0;
        br_n    = 1'b1;
        sb_push("sim_ext", 4'b0101);
        tick(3);
        sb_check();
        bgack_n = 1'b1;
        sb_push("sim_rec", 4'b0101);
        tick(3);
        sb_check();
        sb_push("sim_idle", 4'b0110);
        pulse_c7m();
        sb_check();
        sb_push("sim_lgrant", 4'b1110);
        tick(1);
        sb_check();
        local_req = 1'b0;
        sb_push("sim_ldone", 4'b0110);
        pulse_done();
        sb_check();

        // bus_reset in LOCAL
        local_req = 1'b1;
        sb_push("br_local", 4'b1110);
        tick(1);
        sb_check();
        local_req = 1'b0;
        bus_reset = 1'b1;
        sb_push("busrst_local", 4'b0110);
        tick(1);
        sb_check();
        bus_reset = 1'b0;
        sb_push("busrst_local_after", 4'b0110);
        tick(1);
        sb_check();

        // bus_reset in EXT
        br_n = 1'b0;
        tick(3);
        sb_push("busrst_grant", 4'b0000);
        pulse_c7m();
        sb_check();
        bgack_n = 1'b0;
        br_n    = 1'b1;
        sb_push("busrst_ext_pre", 4'b0101);
        tick(3);
        sb_check();
        bus_reset = 1'b1;
        sb_push("busrst_ext", 4'b0110);
        tick(1);
        sb_check();
        bgack_n = 1'b1;
        tick(3);
        bus_reset = 1'b0;
        tick(1);

        // BR arriving during LOCAL waits for the cycle to finish
        local_req = 1'b1;
        tick(1);
        local_req = 1'b0;
        br_n = 1'b0;
        sb_push("local_br_wait", 4'b1110);
        tick(4);
        sb_check();
        sb_push("local_br_done", 4'b0110);
        pulse_done();
        sb_check();
        tick(1);
        sb_push("local_br_grant", 4'b0000);
        pulse_c7m();
        sb_check();

        // Asynchronous reset mid-GRANT
        #1;
        rst_n = 1'b0;
        #1;
        sb_push("async_rst", 4'b0110);
        sb_check();
        br_n = 1'b1;
        @(negedge c200m);
        rst_n = 1'b1;
        sb_push("post_rst", 4'b0110);
        tick(3);
        sb_check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_m68k_bus_arbiter
`default_nettype wire
